xif_coproc_responder: RTL and testbench

// Coprocessor-side responder for CORE-V-XIF, i.e. the block that sits on the coproc end of the core's issue/commit/result links.

---
 rtl/xif_coproc_pkg.sv | 21 ++
 rtl/xif_coproc_responder_if.sv | 26 ++
 rtl/xif_coproc_alu.sv | 18 +
 rtl/xif_coproc_responder.sv | 73 +++++++
 tb/tb_xif_coproc_responder.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/xif_coproc_pkg.sv
// xif_coproc_pkg: shared types, opcodes and decode helper for the XIF coprocessor responder
package xif_coproc_pkg;
  localparam int XID_W = 4;
  localparam logic [6:0] OPCODE_CUSTOM0 = 7'h0B;
  localparam logic [2:0] FUNCT3_POPCNT = 3'd0;
  localparam logic [2:0] FUNCT3_MINU = 3'd1;
  localparam logic [2:0] FUNCT3_ABSDIFF = 3'd2;
  typedef enum logic [1:0] {POPCNT, MINU, ABSDIFF} op_e;
  typedef enum logic [1:0] {EMPTY, ISSUED, COMMITTED, KILLED} entry_state_e;
  typedef struct packed {
    logic [XID_W-1:0] id;
    logic [4:0] rd;
    logic [31:0] data;
    entry_state_e state;
  } entry_t;
  function automatic logic decode_ok(logic [31:0] instr, logic [6:0] opcode);
    return instr[6:0] == opcode && instr[31:25] == 7'd0 &&
           (instr[14:12] == FUNCT3_POPCNT || instr[14:12] == FUNCT3_MINU ||
            instr[14:12] == FUNCT3_ABSDIFF);
  endfunction
endpackage

// File: rtl/xif_coproc_responder_if.sv
// xif_coproc_responder_if: issue/commit/result links between core (master) and coprocessor (slave)
interface xif_coproc_responder_if #(parameter int X_ID_WIDTH = 4);
  logic issue_valid, issue_ready, issue_accept, issue_writeback;
  logic [31:0] issue_instr;
  logic [X_ID_WIDTH-1:0] issue_id;
  logic [63:0] issue_rs;
  logic [1:0] issue_rs_valid;
  logic commit_valid, commit_kill;
  logic [X_ID_WIDTH-1:0] commit_id;
  logic result_valid, result_ready, result_we;
  logic [X_ID_WIDTH-1:0] result_id;
  logic [31:0] result_data;
  logic [4:0] result_rd;
  modport master (
    output issue_valid, issue_instr, issue_id, issue_rs, issue_rs_valid,
           commit_valid, commit_id, commit_kill, result_ready,
    input  issue_ready, issue_accept, issue_writeback,
           result_valid, result_id, result_data, result_rd, result_we
  );
  modport slave (
    input  issue_valid, issue_instr, issue_id, issue_rs, issue_rs_valid,
           commit_valid, commit_id, commit_kill, result_ready,
    output issue_ready, issue_accept, issue_writeback,
           result_valid, result_id, result_data, result_rd, result_we
  );
endinterface

// File: rtl/xif_coproc_alu.sv
// xif_coproc_alu: combinational POPCNT / MINU / ABSDIFF on 32-bit unsigned operands
module xif_coproc_alu
  import xif_coproc_pkg::*;
(
  input  op_e         op,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  output logic [31:0] res
);
  logic [5:0] ones;
  always_comb begin
    ones = '0;
    for (int i = 0; i < 32; i++) ones = ones + 6'(rs1[i]);
    res = op == POPCNT ? 32'(ones) :
          op == MINU ? (rs1 < rs2 ? rs1 : rs2) :
          (rs1 > rs2 ? rs1 - rs2 : rs2 - rs1);
  end
endmodule

// File: rtl/xif_coproc_responder.sv
// xif_coproc_responder: custom-0 XIF coprocessor holding in-order results until commit
module xif_coproc_responder
  import xif_coproc_pkg::*;
#(
  parameter int X_ID_WIDTH = XID_W,
  parameter int DEPTH = 4,
  parameter logic [6:0] OPCODE = OPCODE_CUSTOM0
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  xif_coproc_responder_if.slave xif,
  output logic                  busy_o
);
  localparam int PW = $clog2(DEPTH);
  entry_t entries [DEPTH];
  logic [PW-1:0] head, tail, hit_idx;
  logic [PW:0] count;
  logic supported, full, push, pop, hit;
  logic [2:0] funct3;
  logic [31:0] alu_res;
  op_e op;
  assign supported = decode_ok(xif.issue_instr, OPCODE);
  assign funct3 = xif.issue_instr[14:12];
  assign op = funct3 == FUNCT3_POPCNT ? POPCNT : funct3 == FUNCT3_MINU ? MINU : ABSDIFF;
  assign full = count == (PW+1)'(DEPTH);
  assign xif.issue_ready = supported ? !full && xif.issue_rs_valid == 2'b11 : 1'b1;
  assign xif.issue_accept = supported;
  assign xif.issue_writeback = supported;
  assign push = xif.issue_valid && xif.issue_ready && supported;
  // killed heads drain silently; committed heads wait for the result handshake
  assign pop = entries[head].state == KILLED ||
               (entries[head].state == COMMITTED && xif.result_ready);
  assign xif.result_valid = entries[head].state == COMMITTED;
  assign xif.result_we = xif.result_valid;
  assign xif.result_id = xif.result_valid ? entries[head].id : '0;
  assign xif.result_data = xif.result_valid ? entries[head].data : '0;
  assign xif.result_rd = xif.result_valid ? entries[head].rd : '0;
  assign busy_o = count != '0;
  xif_coproc_alu u_alu (
    .op (op),
    .rs1(xif.issue_rs[31:0]),
    .rs2(xif.issue_rs[63:32]),
    .res(alu_res)
  );
  always_comb begin
    hit = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < DEPTH; i++)
      if (!hit && xif.commit_valid && entries[i].state == ISSUED && entries[i].id == xif.commit_id) begin
        hit = 1'b1;
        hit_idx = PW'(i);
      end
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
      head <= '0;
      tail <= '0;
      count <= '0;
    end else begin
      if (push) begin
        entries[tail] <= '{id: xif.issue_id, rd: xif.issue_instr[11:7], data: alu_res, state: ISSUED};
        tail <= tail + 1'b1;
      end
      if (hit) entries[hit_idx].state <= xif.commit_kill ? KILLED : COMMITTED;
      if (pop) begin
        entries[head].state <= EMPTY;
        head <= head + 1'b1;
      end
      count <= count + (PW+1)'(push) - (PW+1)'(pop);
    end
  end
endmodule

// File: tb/tb_xif_coproc_responder.sv
// tb_xif_coproc_responder: directed and random stimulus against an in-order queue reference model
module tb_xif_coproc_responder;
  typedef struct {
    logic [3:0] id;
    logic [4:0] rd;
    logic [31:0] data;
    int st;
  } ment_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;
  ment_t mq[$];
  int checks = 0;
  int failures = 0;
  int next_id = 0;
  always #5 clk = ~clk;
  xif_coproc_responder_if #(.X_ID_WIDTH(4)) xif ();
  xif_coproc_responder #(.X_ID_WIDTH(4), .DEPTH(4), .OPCODE(7'h0B)) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .xif   (xif.slave),
    .busy_o(busy)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  function automatic logic [31:0] mk(logic [6:0] f7, logic [2:0] f3, logic [4:0] rd, logic [6:0] opc);
    return {f7, 5'd2, 5'd1, f3, rd, opc};
  endfunction
  function automatic bit is_sup(logic [31:0] instr);
    return instr[6:0] == 7'h0B && instr[31:25] == 7'd0 && instr[14:12] < 3'd3;
  endfunction
  function automatic logic [31:0] ref_result(logic [2:0] f3, logic [31:0] a, logic [31:0] b);
    longint d;
    d = longint'(a) - longint'(b);
    if (f3 == 3'd0) return 32'($countones(a));
    if (f3 == 3'd1) return a < b ? a : b;
    return 32'(d < 0 ? -d : d);
  endfunction
  task automatic idle();
    xif.issue_valid = 1'b0;
    xif.issue_instr = '0;
    xif.issue_id = '0;
    xif.issue_rs = '0;
    xif.issue_rs_valid = 2'b11;
    xif.commit_valid = 1'b0;
    xif.commit_id = '0;
    xif.commit_kill = 1'b0;
    xif.result_ready = 1'b1;
  endtask
  task automatic set_issue(input logic v, input logic [31:0] instr, input logic [3:0] id,
                           input logic [31:0] rs1, input logic [31:0] rs2, input logic [1:0] rsv);
    xif.issue_valid = v;
    xif.issue_instr = instr;
    xif.issue_id = id;
    xif.issue_rs = {rs2, rs1};
    xif.issue_rs_valid = rsv;
  endtask
  task automatic set_commit(input logic v, input logic [3:0] id, input logic kill);
    xif.commit_valid = v;
    xif.commit_id = id;
    xif.commit_kill = kill;
  endtask
  // check all outputs against the model for the current inputs, then advance one clock
  task automatic cycle();
    bit sup, rdy, hv, pop, push;
    int idx;
    ment_t ne;
    #1;
    sup = is_sup(xif.issue_instr);
    rdy = sup ? (mq.size() < 4 && xif.issue_rs_valid == 2'b11) : 1'b1;
    hv = mq.size() > 0 && mq[0].st == 1;
    chk("issue_ready", xif.issue_ready, rdy);
    chk("issue_accept", xif.issue_accept, sup);
    chk("issue_writeback", xif.issue_writeback, sup);
    chk("result_valid", xif.result_valid, hv);
    chk("result_we", xif.result_we, hv);
    chk("busy", busy, mq.size() != 0);
    if (hv) begin
      chk("result_id", xif.result_id, mq[0].id);
      chk("result_data", xif.result_data, mq[0].data);
      chk("result_rd", xif.result_rd, mq[0].rd);
    end
    pop = mq.size() > 0 && (mq[0].st == 2 || (mq[0].st == 1 && xif.result_ready));
    idx = -1;
    if (xif.commit_valid)
      foreach (mq[i]) if (idx < 0 && mq[i].st == 0 && mq[i].id == xif.commit_id) idx = i;
    push = xif.issue_valid && rdy && sup;
    ne = '{xif.issue_id, xif.issue_instr[11:7],
           ref_result(xif.issue_instr[14:12], xif.issue_rs[31:0], xif.issue_rs[63:32]), 0};
    if (idx >= 0) mq[idx].st = xif.commit_kill ? 2 : 1;
    @(posedge clk);
    #1;
    if (pop) void'(mq.pop_front());
    if (push) begin
      mq.push_back(ne);
      next_id++;
    end
  endtask
  task automatic drain();
    bit found;
    for (int n = 0; n < 40 && mq.size() > 0; n++) begin
      idle();
      found = 0;
      foreach (mq[i]) if (!found && mq[i].st == 0) begin
        set_commit(1'b1, mq[i].id, 1'b0);
        found = 1;
      end
      cycle();
    end
    idle();
    chk("drain_busy", busy, 1'b0);
  endtask
  initial begin
    idle();
    #2;
    chk("rst_valid", xif.result_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ready", xif.issue_ready, 1'b1);
    chk("rst_data", xif.result_data, 32'd0);
    chk("rst_id", xif.result_id, 4'd0);
    chk("rst_rd", xif.result_rd, 5'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    // POPCNT committed
    set_issue(1'b1, mk(7'd0, 3'd0, 5'd7, 7'h0B), 4'd3, 32'hF0F0_0001, 32'd0, 2'b11);
    cycle();
    idle();
    set_commit(1'b1, 4'd3, 1'b0);
    cycle();
    idle();
    chk("popcnt_valid", xif.result_valid, 1'b1);
    chk("popcnt_data", xif.result_data, 32'd9);
    chk("popcnt_id", xif.result_id, 4'd3);
    chk("popcnt_rd", xif.result_rd, 5'd7);
    cycle();
    // ABSDIFF killed
    set_issue(1'b1, mk(7'd0, 3'd2, 5'd9, 7'h0B), 4'd5, 32'd5, 32'd12, 2'b11);
    cycle();
    idle();
    set_commit(1'b1, 4'd5, 1'b1);
    cycle();
    idle();
    chk("kill_valid", xif.result_valid, 1'b0);
    chk("kill_busy_hold", busy, 1'b1);
    cycle();
    chk("kill_busy_fall", busy, 1'b0);
    // unsupported encodings
    set_issue(1'b1, mk(7'd0, 3'd7, 5'd3, 7'h0B), 4'd6, 32'd1, 32'd2, 2'b11);
    cycle();
    set_issue(1'b1, mk(7'd0, 3'd1, 5'd3, 7'h2B), 4'd6, 32'd1, 32'd2, 2'b11);
    cycle();
    set_issue(1'b1, mk(7'd1, 3'd1, 5'd3, 7'h0B), 4'd6, 32'd1, 32'd2, 2'b01);
    cycle();
    idle();
    chk("unsup_busy", busy, 1'b0);
    // fill to DEPTH, then a fifth supported issue must stall
    for (int k = 0; k < 4; k++) begin
      set_issue(1'b1, mk(7'd0, 3'd1, 5'(k + 1), 7'h0B), 4'(k), $urandom, $urandom, 2'b11);
      cycle();
    end
    set_issue(1'b1, mk(7'd0, 3'd1, 5'd5, 7'h0B), 4'd4, 32'd77, 32'd66, 2'b11);
    #1 chk("full_ready", xif.issue_ready, 1'b0);
    cycle();
    set_commit(1'b1, 4'd0, 1'b0);
    cycle();
    set_commit(1'b0, 4'd0, 1'b0);
    cycle();
    #1 chk("after_pop_ready", xif.issue_ready, 1'b1);
    cycle();
    xif.issue_valid = 1'b0;
    drain();
    // out-of-order commit with backpressure
    set_issue(1'b1, mk(7'd0, 3'd2, 5'd10, 7'h0B), 4'd0, 32'd100, 32'd40, 2'b11);
    cycle();
    set_issue(1'b1, mk(7'd0, 3'd0, 5'd11, 7'h0B), 4'd1, 32'hFFFF_FFFF, 32'd0, 2'b11);
    cycle();
    idle();
    xif.result_ready = 1'b0;
    set_commit(1'b1, 4'd1, 1'b0);
    cycle();
    chk("ooo_wait", xif.result_valid, 1'b0);
    set_commit(1'b1, 4'd0, 1'b0);
    cycle();
    set_commit(1'b0, 4'd0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      chk("hold_id", xif.result_id, 4'd0);
      chk("hold_data", xif.result_data, 32'd60);
      cycle();
    end
    xif.result_ready = 1'b1;
    cycle();
    chk("second_id", xif.result_id, 4'd1);
    chk("second_data", xif.result_data, 32'd32);
    drain();
    // operand-valid stall, then reset with three live entries
    set_issue(1'b1, mk(7'd0, 3'd1, 5'd12, 7'h0B), 4'd8, 32'd9, 32'd4, 2'b01);
    cycle();
    cycle();
    xif.issue_rs_valid = 2'b11;
    cycle();
    set_issue(1'b1, mk(7'd0, 3'd0, 5'd13, 7'h0B), 4'd9, 32'h7, 32'd0, 2'b11);
    cycle();
    set_issue(1'b1, mk(7'd0, 3'd2, 5'd14, 7'h0B), 4'd10, 32'd3, 32'd8, 2'b11);
    set_commit(1'b1, 4'd8, 1'b0);
    xif.result_ready = 1'b0;
    cycle();
    idle();
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_valid", xif.result_valid, 1'b0);
    mq.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    set_commit(1'b1, 4'd9, 1'b0);
    cycle();
    idle();
    cycle();
    cycle();
    // random traffic
    next_id = 0;
    for (int n = 0; n < 400; n++) begin
      idle();
      if ($urandom % 3 != 0)
        set_issue(1'b1,
                  mk(($urandom % 10 == 0) ? 7'd1 : 7'd0, 3'($urandom % 4), 5'($urandom),
                     ($urandom % 8 == 0) ? 7'h2B : 7'h0B),
                  4'(next_id), ($urandom % 4 == 0) ? 32'($urandom % 16) : 32'($urandom),
                  ($urandom % 4 == 0) ? 32'($urandom % 16) : 32'($urandom),
                  ($urandom % 6 == 0) ? 2'b01 : 2'b11);
      if ($urandom % 2 == 0) begin
        if (mq.size() > 0 && $urandom % 4 != 0)
          set_commit(1'b1, mq[$urandom % mq.size()].id, $urandom % 4 == 0);
        else
          set_commit(1'b1, 4'($urandom), $urandom % 4 == 0);
      end
      xif.result_ready = $urandom % 3 != 0;
      cycle();
    end
    drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
